// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared external-bus constants, responder states and default widths
package mem_bus_pkg;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: word-addressed storage, synchronous write and combinational read, no reset
module mem_array #(
  parameter int DATA_W = mem_bus_pkg::DEF_DATA_W,
  parameter int ADDR_W = mem_bus_pkg::DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clock) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory end of the external data bus with fixed wait states and one-cycle ack
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] edb,
  output logic              ack,
  output logic              busy
);
  localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
  state_t state, next;
  logic [3:0] cnt, cnt_n;
  logic rw_q, acc, rd_now, we;
  logic [ADDR_W-1:0] addr_q, raddr;
  logic [DATA_W-1:0] data_q, rdata;
  always_comb begin
    acc = state == IDLE && req;
    next = state == IDLE ? (req ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
         : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_n = acc ? CNT_INIT : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    // with zero wait states the read happens in the accepting cycle, before the latches load
    raddr = state == IDLE ? addr_in : addr_q;
    rd_now = state == IDLE ? rw : rw_q;
    we = state == RESP && rw_q == WRITE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rw_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      edb <= '0;
      ack <= 1'b0;
    end else begin
      state <= next;
      cnt <= cnt_n;
      ack <= next == RESP;
      if (acc) begin
        rw_q <= rw;
        addr_q <= addr_in;
        data_q <= data_in;
      end
      if (next == RESP && rd_now == READ) edb <= rdata;
    end
  end
  assign busy = state != IDLE;
  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clock(clock),
    .we(we),
    .waddr(addr_q),
    .wdata(data_q),
    .raddr(raddr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench with a read-data scoreboard, zero-wait and one-wait instances
module tb_mem_responder;
  import mem_bus_pkg::*;
  logic clock = 1'b0;
  logic reset;
  logic req [2];
  logic rw [2];
  logic [7:0] addr [2];
  logic [15:0] din [2];
  logic [15:0] edb [2];
  logic ack [2];
  logic busy [2];
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb [$];

  always #5 clock = ~clock;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) u0 (
    .clock(clock), .reset(reset), .req(req[0]), .rw(rw[0]), .addr_in(addr[0]),
    .data_in(din[0]), .edb(edb[0]), .ack(ack[0]), .busy(busy[0])
  );
  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(1)) u1 (
    .clock(clock), .reset(reset), .req(req[1]), .rw(rw[1]), .addr_in(addr[1]),
    .data_in(din[1]), .edb(edb[1]), .ack(ack[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // s selects the instance and equals its wait-state count; mut disturbs inputs after acceptance
  task automatic xact(input int s, input logic r, input logic [7:0] a, input logic [15:0] d,
                      input logic [15:0] e, input bit mut);
    int lat;
    @(negedge clock);
    req[s] = 1'b1; rw[s] = r; addr[s] = a; din[s] = d;
    if (r == READ) sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    req[s] = 1'b0;
    if (mut) begin addr[s] = a + 8'd1; din[s] = 16'h0; rw[s] = ~r; end
    chk("busy_after_accept", 32'(busy[s]), 32'd1);
    lat = 1;
    while (!ack[s] && lat < 10) begin @(negedge clock); lat++; end
    chk("ack_latency", 32'(lat), 32'(s + 1));
    if (r == READ) chk("read_data", 32'(edb[s]), 32'(sb.pop_front()));
    @(negedge clock);
    chk("ack_one_cycle", 32'(ack[s]), 32'd0);
    chk("busy_after_ack", 32'(busy[s]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, last, k;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; din[i] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ack", 32'(ack[i]), 32'd0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
      chk("reset_edb", 32'(edb[i]), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;

    // reset in the middle of a write's wait state
    xact(1, WRITE, 8'h10, 16'h1111, 16'h0, 1'b0);
    xact(1, READ, 8'h10, 16'h0, 16'h1111, 1'b0);
    @(negedge clock);
    req[1] = 1'b1; rw[1] = WRITE; addr[1] = 8'h10; din[1] = 16'hBEEF;
    @(posedge clock);
    @(negedge clock);
    req[1] = 1'b0;
    chk("in_wait_busy", 32'(busy[1]), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_ack", 32'(ack[1]), 32'd0);
    chk("abort_busy", 32'(busy[1]), 32'd0);
    chk("abort_edb", 32'(edb[1]), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    xact(1, READ, 8'h10, 16'h0, 16'h1111, 1'b0);

    // write then read with one wait state, edb holds afterwards
    xact(1, WRITE, 8'h05, 16'h1234, 16'h0, 1'b0);
    xact(1, READ, 8'h05, 16'h0, 16'h1234, 1'b0);
    repeat (3) @(negedge clock);
    chk("edb_hold_idle", 32'(edb[1]), 32'h1234);
    xact(1, WRITE, 8'h06, 16'h4321, 16'h0, 1'b0);
    chk("edb_hold_write", 32'(edb[1]), 32'h1234);

    // zero wait states
    xact(0, WRITE, 8'h00, 16'hA5A5, 16'h0, 1'b0);
    xact(0, READ, 8'h00, 16'h0, 16'hA5A5, 1'b0);

    // back-to-back reads with req held high
    xact(1, WRITE, 8'h01, 16'h0011, 16'h0, 1'b0);
    xact(1, WRITE, 8'h02, 16'h0022, 16'h0, 1'b0);
    xact(1, WRITE, 8'h03, 16'h0033, 16'h0, 1'b0);
    @(negedge clock);
    req[1] = 1'b1; rw[1] = READ; addr[1] = 8'h01;
    sb.push_back(16'h0011); sb.push_back(16'h0022); sb.push_back(16'h0033);
    cyc = 0; last = 0; k = 0;
    while (k < 3 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (ack[1]) begin
        chk("b2b_data", 32'(edb[1]), 32'(sb.pop_front()));
        if (k > 0) chk("b2b_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        k++;
        if (k < 3) addr[1] = 8'(k + 1);
        else req[1] = 1'b0;
      end
    end
    chk("b2b_count", 32'(k), 32'd3);
    repeat (2) @(negedge clock);
    chk("b2b_idle", 32'(busy[1]), 32'd0);

    // inputs changed after acceptance must not affect the write
    xact(1, WRITE, 8'h21, 16'h5555, 16'h0, 1'b0);
    xact(1, WRITE, 8'h20, 16'h7777, 16'h0, 1'b1);
    xact(1, READ, 8'h20, 16'h0, 16'h7777, 1'b0);
    xact(1, READ, 8'h21, 16'h0, 16'h5555, 1'b0);

    // top address does not alias onto address zero
    xact(1, WRITE, 8'h00, 16'h0A0A, 16'h0, 1'b0);
    xact(1, WRITE, 8'hFF, 16'hFFFF, 16'h0, 1'b0);
    xact(1, READ, 8'hFF, 16'h0, 16'hFFFF, 1'b0);
    xact(1, READ, 8'h00, 16'h0, 16'h0A0A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
